// File: rtl/dma_pkg.sv
// Shared constants and FSM state type for the 112-bit row to 64-bit beat unpacker.
// A 14-byte row is unpacked into 8-byte beats; a 196-byte block ends on a half beat.
// The tail beat carries the last 4 bytes of a block under a low-nibble strobe.
package dma_pkg;

  localparam int         ROW_BYTES       = 14;
  localparam int         BEAT_BYTES      = 8;
  localparam int         BEATS_PER_BLOCK = 25;
  localparam logic [7:0] TAIL_STRB       = 8'h0F;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_e;

endpackage

// File: rtl/dma_unpack_112.sv
// Unpacks blocks of 112-bit buffer rows into 64-bit DMA beats, zero-padded, strobed tail per block.
// Latency: first beat valid 3 cycles after start (1-cycle row read plus capture).
// Backpressure: beat held stable until dma_ready; no row fetch while a full beat is stalled.
module dma_unpack_112
  import dma_pkg::*;
#(
  parameter int IN_W           = ROW_BYTES * 8,
  parameter int ADDR_W         = 10,
  parameter int ROWS_PER_BLOCK = 14
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [7:0]        n_blocks,
  output logic              busy,
  output logic              done,
  output logic              buf_re,
  output logic [ADDR_W-1:0] buf_raddr,
  input  logic [IN_W-1:0]   buf_rdata,
  output logic              dma_valid,
  input  logic              dma_ready,
  output logic [63:0]       dma_wdata,
  output logic [7:0]        dma_strb,
  output logic              dma_last
);

  localparam int         BEAT_W   = BEAT_BYTES * 8;
  // Residue never exceeds 48 leftover bits plus one freshly captured row.
  localparam int         SR_W     = IN_W + 48;
  localparam logic [7:0] ROWS_L   = 8'(ROWS_PER_BLOCK);
  localparam logic [7:0] CNT_BEAT = 8'(BEAT_W);
  localparam logic [7:0] CNT_ROW  = 8'(IN_W);
  localparam logic [7:0] CNT_TAIL = 8'd32;

  state_e            state_q, state_d;
  logic [SR_W-1:0]   sr_q, sr_d;
  logic [7:0]        cnt_q, cnt_d;
  logic [7:0]        rows_q, rows_d;
  logic [7:0]        blocks_q, blocks_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              inflight_q;

  logic              rows_left;
  logic              tail;
  logic              beat_vld;
  logic              fire;
  logic [7:0]        cnt_post;
  logic              rd_issue;
  logic [SR_W-1:0]   sr_sh;
  logic [SR_W-1:0]   row_ext;

  assign row_ext = {{(SR_W-IN_W){1'b0}}, buf_rdata};

  // Decode beat availability, tail condition and read issue from the current residue.
  always_comb begin
    rows_left = (rows_q < ROWS_L);
    tail      = (state_q == RUN) && !rows_left && !inflight_q && (cnt_q == CNT_TAIL);
    beat_vld  = (state_q == RUN) && ((cnt_q >= CNT_BEAT) || tail);
    fire      = beat_vld && dma_ready;
    cnt_post  = (fire && !tail) ? (cnt_q - CNT_BEAT) : cnt_q;
    // Only fetch when the residue after this cycle's beat cannot form another full beat,
    // so a capture never lands while an unaccepted beat is pending.
    rd_issue  = (state_q == RUN) && !inflight_q && rows_left && (cnt_post < CNT_BEAT);
  end

  // Next-state logic: FSM, residue shift/merge, row and block bookkeeping.
  always_comb begin
    state_d  = state_q;
    sr_d     = sr_q;
    cnt_d    = cnt_q;
    rows_d   = rows_q;
    blocks_d = blocks_q;
    addr_d   = addr_q;
    sr_sh    = sr_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          addr_d   = base_addr;
          blocks_d = n_blocks;
          sr_d     = '0;
          cnt_d    = '0;
          rows_d   = '0;
          state_d  = (n_blocks == 8'd0) ? DONE : RUN;
        end
      end
      RUN: begin
        if (tail && fire) begin
          // Blocks are independent: drop the padding residue and restart the row count.
          sr_d     = '0;
          cnt_d    = '0;
          rows_d   = '0;
          blocks_d = blocks_q - 8'd1;
          if (blocks_q == 8'd1) begin
            state_d = DONE;
          end
        end else begin
          sr_sh = fire ? (sr_q >> BEAT_W) : sr_q;
          if (inflight_q) begin
            sr_d  = sr_sh | (row_ext << cnt_post);
            cnt_d = cnt_post + CNT_ROW;
          end else begin
            sr_d  = sr_sh;
            cnt_d = cnt_post;
          end
          if (rd_issue) begin
            rows_d = rows_q + 8'd1;
            addr_d = addr_q + {{(ADDR_W-1){1'b0}}, 1'b1};
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers; reset discards any in-flight row.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      sr_q       <= '0;
      cnt_q      <= '0;
      rows_q     <= '0;
      blocks_q   <= '0;
      addr_q     <= '0;
      inflight_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      sr_q       <= sr_d;
      cnt_q      <= cnt_d;
      rows_q     <= rows_d;
      blocks_q   <= blocks_d;
      addr_q     <= addr_d;
      inflight_q <= rd_issue;
    end
  end

  assign busy      = (state_q == RUN);
  assign done      = (state_q == DONE);
  assign buf_re    = rd_issue;
  assign buf_raddr = addr_q;
  assign dma_valid = beat_vld;
  assign dma_last  = tail;
  assign dma_wdata = tail ? {{(BEAT_W-32){1'b0}}, sr_q[31:0]} : sr_q[BEAT_W-1:0];
  assign dma_strb  = beat_vld ? (tail ? TAIL_STRB : 8'hFF) : 8'h00;

endmodule
